// File: rtl/alu02_seq_if.sv
// Handshake bundle between an operand source, the alu02_seq ALU and a result sink.
// The master modport is the source/sink side; the slave modport is the ALU.
interface alu02_seq_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [3:0]         op;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               flag_z;
  logic               flag_n;
  logic               flag_c;
  logic               flag_v;
  logic               err;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, err
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, err
  );
endinterface

// File: rtl/alu02_seq.sv
// Registered ALU with valid/ready handshakes, status flags and a multi-cycle
// shift-add multiplier. One operation in flight: single-cycle ops produce their
// result one cycle after accept, MUL takes WIDTH iterations before reporting.
module alu02_seq #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  alu02_seq_if.slave bus
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] ONE     = (WIDTH + 1)'(1);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_NOT  = 4'b0101,
    OP_SHL  = 4'b0110,
    OP_SHR  = 4'b0111,
    OP_INC  = 4'b1000,
    OP_DEC  = 4'b1001,
    OP_PASS = 4'b1010,
    OP_MUL  = 4'b1011,
    OP_CMP  = 4'b1100
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             r_state;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_result;
  logic               r_z, r_n, r_c, r_v, r_err;

  // Multiplier working registers; result register is only written at completion.
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_is_mul;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic               w_sub_v;
  logic               w_v;
  logic               w_cmp;
  logic               w_err;
  logic               w_z, w_n, w_c;
  logic [2*WIDTH-1:0] w_result;
  logic [2*WIDTH-1:0] w_acc_next;

  // Accept in IDLE, or in DONE when the sink takes the current result this cycle.
  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_mul   = (bus.op == OP_MUL);

  // Single-cycle datapath evaluated on the live operands; registered at accept.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    w_sum   = '0;
    w_v     = 1'b0;
    w_cmp   = 1'b0;
    w_err   = 1'b0;
    w_diff  = {1'b0, bus.a} - {1'b0, bus.b};
    w_sub_v = (bus.a[MSB] != bus.b[MSB]) && (w_diff[MSB] != bus.a[MSB]);
    case (bus.op)
      OP_ADD: begin
        w_sum = {1'b0, bus.a} + {1'b0, bus.b};
        w_v   = (bus.a[MSB] == bus.b[MSB]) && (w_sum[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        w_sum = w_diff;
        w_v   = w_sub_v;
      end
      OP_AND:  w_sum = {1'b0, bus.a & bus.b};
      OP_OR:   w_sum = {1'b0, bus.a | bus.b};
      OP_XOR:  w_sum = {1'b0, bus.a ^ bus.b};
      OP_NOT:  w_sum = {1'b0, ~bus.a};
      OP_SHL:  w_sum = {bus.a, 1'b0};
      OP_SHR:  w_sum = {bus.a[0], 1'b0, bus.a[MSB:1]};
      OP_INC: begin
        w_sum = {1'b0, bus.a} + ONE;
        w_v   = (bus.a == {1'b0, {(WIDTH-1){1'b1}}});
      end
      OP_DEC: begin
        w_sum = {1'b0, bus.a} - ONE;
        w_v   = (bus.a == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_PASS: w_sum = {1'b0, bus.b};
      OP_MUL:  w_sum = '0;
      OP_CMP: begin
        w_cmp = 1'b1;
        w_v   = w_sub_v;
      end
      default: w_err = 1'b1;
    endcase
  end

  // CMP reports on the difference but leaves result at zero; illegal ops clear all flags.
  assign w_z      = !w_err && (w_cmp ? (w_diff[MSB:0] == '0) : (w_sum == '0));
  assign w_n      = w_cmp ? w_diff[MSB]   : w_sum[MSB];
  assign w_c      = w_cmp ? w_diff[WIDTH] : w_sum[WIDTH];
  assign w_result = {{(WIDTH-1){1'b0}}, w_sum};

  // One partial product per MUL cycle; the final iteration folds in directly.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Control FSM and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_err       <= 1'b0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
    end else begin
      // NOTE: state is updated with <= so every register samples pre-edge values.
      case (r_state)
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
            r_result    <= w_acc_next;
            r_z         <= (w_acc_next == '0);
            r_n         <= w_acc_next[2*WIDTH-1];
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        default: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_acc       <= '0;
              r_mcand     <= {{WIDTH{1'b0}}, bus.a};
              r_mplier    <= bus.b;
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_state     <= S_MUL;
            end else begin
              r_result    <= w_result;
              r_z         <= w_z;
              r_n         <= w_n;
              r_c         <= w_c;
              r_v         <= w_v;
              r_err       <= w_err;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end else if ((r_state == S_DONE) && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flag_z    = r_z;
  assign bus.flag_n    = r_n;
  assign bus.flag_c    = r_c;
  assign bus.flag_v    = r_v;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_alu02_seq.sv
// Self-checking bench for alu02_seq (WIDTH=8): table-driven vectors through a
// scoreboard, plus hand sequences for backpressure, MUL timing and mid-MUL reset.
module tb_alu02_seq;

  typedef struct packed {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic [4:0]  flg;   // {z, n, c, v, err}
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc_cyc;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu02_seq_if #(.WIDTH(8)) bus ();

  alu02_seq #(.WIDTH(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  vec_t exp_cur;
  sb_t  q[$];
  bit   head_seen = 1'b0;
  vec_t vecs[33];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: samples one time unit before each rising edge.
  always begin
    @(negedge clk);
    #4;
    cyc++;
    if (rst) begin
      q.delete();
      head_seen = 1'b0;
    end else begin
      if (bus.out_valid && !head_seen) begin
        if (q.size() == 0) check("spurious_out_valid", 32'd1, 32'd0);
        else begin
          check("latency", cyc - q[0].acc_cyc, (q[0].v.op == 4'hB) ? 9 : 1);
          head_seen = 1'b1;
        end
      end
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        sb_t h;
        h = q.pop_front();
        check($sformatf("result op=%0h a=%0h b=%0h", h.v.op, h.v.a, h.v.b), bus.result, h.v.res);
        check($sformatf("flags op=%0h a=%0h b=%0h", h.v.op, h.v.a, h.v.b),
              {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.err}, h.v.flg);
        head_seen = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) q.push_back('{v: exp_cur, acc_cyc: cyc});
    end
  end

  // Present one operation at a falling edge and hold it until accepted.
  task automatic send(input vec_t v);
    int waits = 0;
    exp_cur      = v;
    bus.op       = v.op;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.in_valid = 1'b1;
    forever begin
      #4;
      if (bus.in_ready) begin
        @(negedge clk);
        break;
      end
      @(negedge clk);
      waits++;
      if (waits > 40) begin
        check("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0;
    int   low;
    vec_t v;

    vecs[0]  = '{4'h0, 8'h6B, 8'hAA, 16'h0115, 5'b00100};
    vecs[1]  = '{4'h1, 8'h6B, 8'hAA, 16'h01C1, 5'b01110};
    vecs[2]  = '{4'h2, 8'h6B, 8'hAA, 16'h002A, 5'b00000};
    vecs[3]  = '{4'h3, 8'h6B, 8'hAA, 16'h00EB, 5'b01000};
    vecs[4]  = '{4'h4, 8'h6B, 8'hAA, 16'h00C1, 5'b01000};
    vecs[5]  = '{4'h5, 8'h6B, 8'hAA, 16'h0094, 5'b01000};
    vecs[6]  = '{4'h6, 8'h6B, 8'hAA, 16'h00D6, 5'b01000};
    vecs[7]  = '{4'h7, 8'h6B, 8'hAA, 16'h0135, 5'b00100};
    vecs[8]  = '{4'h8, 8'h6B, 8'hAA, 16'h006C, 5'b00000};
    vecs[9]  = '{4'h9, 8'h6B, 8'hAA, 16'h006A, 5'b00000};
    vecs[10] = '{4'hA, 8'h6B, 8'hAA, 16'h00AA, 5'b01000};
    vecs[11] = '{4'hB, 8'hFF, 8'hFF, 16'hFE01, 5'b01000};
    vecs[12] = '{4'hC, 8'h6B, 8'hAA, 16'h0000, 5'b01110};
    vecs[13] = '{4'hE, 8'h6B, 8'hAA, 16'h0000, 5'b00001};
    vecs[14] = '{4'h8, 8'hFF, 8'h00, 16'h0100, 5'b00100};
    vecs[15] = '{4'h8, 8'h7F, 8'h00, 16'h0080, 5'b01010};
    vecs[16] = '{4'h9, 8'h80, 8'h00, 16'h007F, 5'b00010};
    vecs[17] = '{4'h9, 8'h00, 8'h00, 16'h01FF, 5'b01100};
    vecs[18] = '{4'h0, 8'h00, 8'h00, 16'h0000, 5'b10000};
    vecs[19] = '{4'h1, 8'h55, 8'h55, 16'h0000, 5'b10000};
    vecs[20] = '{4'hC, 8'h55, 8'h55, 16'h0000, 5'b10000};
    vecs[21] = '{4'h0, 8'h7F, 8'h01, 16'h0080, 5'b01010};
    vecs[22] = '{4'hB, 8'h00, 8'h37, 16'h0000, 5'b10000};
    vecs[23] = '{4'hB, 8'h0F, 8'h0F, 16'h00E1, 5'b00000};
    vecs[24] = '{4'h6, 8'h80, 8'h00, 16'h0100, 5'b00100};
    vecs[25] = '{4'hD, 8'h12, 8'h34, 16'h0000, 5'b00001};
    vecs[26] = '{4'hF, 8'hFF, 8'hFF, 16'h0000, 5'b00001};
    vecs[27] = '{4'h4, 8'hAA, 8'hAA, 16'h0000, 5'b10000};
    vecs[28] = '{4'h1, 8'h00, 8'h01, 16'h01FF, 5'b01100};
    vecs[29] = '{4'h1, 8'h80, 8'h01, 16'h007F, 5'b00010};
    vecs[30] = '{4'h0, 8'h80, 8'h80, 16'h0100, 5'b00110};
    vecs[31] = '{4'hB, 8'h80, 8'h02, 16'h0100, 5'b00000};
    vecs[32] = '{4'hB, 8'hFF, 8'h01, 16'h00FF, 5'b00000};

    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    exp_cur       = '0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #4;
    check("reset out_valid", bus.out_valid, 0);
    check("reset result", bus.result, 0);
    check("reset flags", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.err}, 0);
    check("reset in_ready", bus.in_ready, 1);
    @(negedge clk);

    // Back-to-back single-cycle ops 0000-1010: one accept per cycle
    c0 = cyc;
    for (int i = 0; i < 11; i++) send(vecs[i]);
    check("b2b cycles", cyc - c0, 11);

    // Remaining vectors, including MUL and illegal ops
    for (int i = 11; i < 33; i++) send(vecs[i]);
    drain();

    // Backpressure: result held, no accept while the sink stalls
    bus.out_ready = 1'b0;
    send(vecs[0]);
    v = '{4'hA, 8'h00, 8'h11, 16'h0011, 5'b00000};
    exp_cur      = v;
    bus.op       = v.op;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #4;
      check("hold out_valid", bus.out_valid, 1);
      check("hold result", bus.result, 16'h0115);
      check("hold in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #4;
    check("release in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    drain();

    // MUL FF*FF: in_ready low for exactly WIDTH cycles
    send(vecs[11]);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      #4;
      if (bus.out_valid) break;
      if (!bus.in_ready) low++;
      @(negedge clk);
    end
    check("mul in_ready low cycles", low, 8);
    drain();

    // Reset during MUL drops the transaction immediately
    send(vecs[23]);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midmul rst out_valid", bus.out_valid, 0);
    check("midmul rst in_ready", bus.in_ready, 1);
    check("midmul rst result", bus.result, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      #4;
      check("post rst no out_valid", bus.out_valid, 0);
      @(negedge clk);
    end
    send('{4'h0, 8'h01, 8'h02, 16'h0003, 5'b00000});
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
